axis_ll_bridge_reg: RTL and testbench
=====================================

Name: axis_ll_bridge_reg

Overview:
- Registered AXI4-Stream to LocalLink bridge. It is the transmit-direction counterpart of the LocalLink-to-AXIS bridge.
- Converts an AXI stream (tdata/tvalid/tready/tlast) into active-low LocalLink (data/sof_n/eof_n/src_rdy_n/dst_rdy_n).
- Generates SOF from frame-position tracking.
- Uses a 2-entry skid buffer, so every output and s_axis_tready are driven from registers. Sits at the boundary between AXIS pipelines and legacy LocalLink cores.

Parameters:
- DATA_WIDTH, 8, width of tdata and LocalLink data.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  DATA_WIDTH  AXI input data
- s_axis_tvalid  input  1  AXI input valid
- s_axis_tready  output  1  AXI input ready (registered)
- s_axis_tlast  input  1  AXI end of frame
- ll_data_out  output  DATA_WIDTH  LocalLink data
- ll_sof_out_n  output  1  start of frame, active low
- ll_eof_out_n  output  1  end of frame, active low
- ll_src_rdy_out_n  output  1  source ready, active low
- ll_dst_rdy_in_n  input  1  destination ready, active low
- status_busy  output  1  input side is mid-frame: first beat accepted, tlast not yet accepted
- status_frame_done  output  1  one-cycle pulse when an EOF beat transfers on LocalLink

Behaviour:
- Reset: the clock and reset are already decided. There is one clock, clk, and the reset rst_n is asynchronous and active-low. While rst_n=0:
  - s_axis_tready=0, ll_src_rdy_out_n=1, ll_sof_out_n=1, ll_eof_out_n=1.
  - ll_data_out=0, status_busy=0, status_frame_done=0.
  - Both buffer entries are invalid and in_frame=0.
  - s_axis_tready rises on the first clk edge after rst_n deasserts.
- Input transfer: s_axis_tvalid=1 and s_axis_tready=1 on a clk edge.
- Output transfer: ll_src_rdy_out_n=0 and ll_dst_rdy_in_n=0 on a clk edge.
- SOF tag: sof=!in_frame is computed at input acceptance and stored with the beat as {data, sof, last}.
  - in_frame is set on an accepted beat with tlast=0 and cleared on an accepted beat with tlast=1.
  - A single-beat frame (tlast=1 and in_frame=0) outputs sof_n=0 and eof_n=0 on the same beat.
- Skid buffer: output register (OUT) plus temp register (TMP).
  - OUT empty or draining this cycle, TMP empty: the input beat goes directly to OUT.
  - OUT full and stalled (ll_dst_rdy_in_n=1), input accepted: the beat goes to TMP.
  - OUT draining and TMP full: TMP moves to OUT; the input beat, if accepted, goes to TMP only if TMP is freed. Since tready was 0, none is accepted.
  - s_axis_tready_next = !TMP_valid_next. In practice tready drops the cycle after TMP fills and returns the cycle after TMP drains.
- Latency is 1 cycle from input acceptance to ll_src_rdy_out_n=0 when OUT is empty.
- Throughput is 1 beat/cycle sustained when ll_dst_rdy_in_n=0 continuously.
- Ordering is strict FIFO with no drop or duplication. Held data must stay stable while ll_src_rdy_out_n=0 and ll_dst_rdy_in_n=1.
- ll_sof_out_n and ll_eof_out_n are meaningful only when ll_src_rdy_out_n=0; otherwise they are driven 1.
- status_frame_done is registered: it is 1 in the cycle after an output transfer with eof_n=0, else 0.
- Simultaneous input and output transfer with TMP empty: OUT is reloaded with the new beat and there is no bubble.
- Reset mid-frame: all buffered beats are discarded. The next accepted beat is tagged SOF. No EOF is emitted for the truncated frame.
- ll_dst_rdy_in_n toggling every cycle must cause no loss, with s_axis_tvalid held high.

Test Plan:
- Reset release, then a 4-beat frame 0x11,0x22,0x33,0x44 (tlast on 0x44), dst ready always: output on consecutive cycles, 1-cycle latency. sof_n=0 on 0x11 only, eof_n=0 on 0x44 only. frame_done pulses once.
- Back-to-back single-beat frames 0xA0,0xA1,0xA2, each with tlast=1: each output beat has sof_n=0 and eof_n=0. frame_done pulses 3 times on consecutive cycles.
- 8-beat frame 0x00..0x07 with ll_dst_rdy_in_n held 1 for 5 cycles mid-frame:
  - s_axis_tready deasserts after at most 2 beats are buffered.
  - ll_data_out is stable during the stall.
  - All 8 beats arrive in order with no gaps after release.
- Random tvalid and random ll_dst_rdy_in_n (50%) over 200 frames of 1–16 random beats: the output sequence equals the input sequence. SOF/EOF mark exact frame boundaries. frame_done count = 200.
- Assert rst_n=0 asynchronously mid-frame after 3 of 6 beats are accepted: outputs go to reset values immediately, without waiting for clk. A new frame 0x55,0x66 then starts with sof_n=0 on 0x55.
- status_busy is 1 from the cycle after the first beat of a 3-beat frame is accepted until the cycle after tlast is accepted, and 0 before and after.

Source files
------------

// File: rtl/axis_ll_bridge_reg.sv
`default_nettype none
// ============================================================================
// axis_ll_bridge_reg : registered AXI4-Stream to active-low LocalLink bridge
//                      with 2-entry skid buffer and SOF tagging.
// Revision 1.0
// ============================================================================
module axis_ll_bridge_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] ll_data_out,
  output logic                  ll_sof_out_n,
  output logic                  ll_eof_out_n,
  output logic                  ll_src_rdy_out_n,
  input  logic                  ll_dst_rdy_in_n,
  output logic                  status_busy,
  output logic                  status_frame_done
);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  src_rdy_n_q, src_rdy_n_d;
  logic                  sof_n_q, sof_n_d;
  logic                  eof_n_q, eof_n_d;
  logic [DATA_WIDTH-1:0] tmp_data_q, tmp_data_d;
  logic                  tmp_vld_q, tmp_vld_d;
  logic                  tmp_sof_q, tmp_sof_d;
  logic                  tmp_last_q, tmp_last_d;
  logic                  in_frame_q, in_frame_d;
  logic                  tready_q, tready_d;
  logic                  frame_done_q, frame_done_d;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_out_free;

  assign w_in_xfer  = s_axis_tvalid & tready_q;
  assign w_out_xfer = ~src_rdy_n_q & ~ll_dst_rdy_in_n;
  assign w_out_free = w_out_xfer | src_rdy_n_q;

  always_comb begin
    out_data_d   = out_data_q;
    src_rdy_n_d  = src_rdy_n_q;
    sof_n_d      = sof_n_q;
    eof_n_d      = eof_n_q;
    tmp_data_d   = tmp_data_q;
    tmp_vld_d    = tmp_vld_q;
    tmp_sof_d    = tmp_sof_q;
    tmp_last_d   = tmp_last_q;
    in_frame_d   = in_frame_q;
    frame_done_d = w_out_xfer & ~eof_n_q;

    if (w_out_free && tmp_vld_q) begin
      out_data_d  = tmp_data_q;
      src_rdy_n_d = 1'b0;
      sof_n_d     = ~tmp_sof_q;
      eof_n_d     = ~tmp_last_q;
      tmp_vld_d   = 1'b0;
    end else if (w_out_free && w_in_xfer) begin
      // Bypass TMP: SOF tag is the inverse of the current frame state.
      out_data_d  = s_axis_tdata;
      src_rdy_n_d = 1'b0;
      sof_n_d     = in_frame_q;
      eof_n_d     = ~s_axis_tlast;
    end else if (w_out_free) begin
      src_rdy_n_d = 1'b1;
      sof_n_d     = 1'b1;
      eof_n_d     = 1'b1;
    end

    if (w_in_xfer && !(w_out_free && !tmp_vld_q)) begin
      tmp_data_d = s_axis_tdata;
      tmp_sof_d  = ~in_frame_q;
      tmp_last_d = s_axis_tlast;
      tmp_vld_d  = 1'b1;
    end

    if (w_in_xfer) begin
      in_frame_d = ~s_axis_tlast;
    end

    tready_d = ~tmp_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      src_rdy_n_q  <= 1'b1;
      sof_n_q      <= 1'b1;
      eof_n_q      <= 1'b1;
      tmp_data_q   <= '0;
      tmp_vld_q    <= 1'b0;
      tmp_sof_q    <= 1'b0;
      tmp_last_q   <= 1'b0;
      in_frame_q   <= 1'b0;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      src_rdy_n_q  <= src_rdy_n_d;
      sof_n_q      <= sof_n_d;
      eof_n_q      <= eof_n_d;
      tmp_data_q   <= tmp_data_d;
      tmp_vld_q    <= tmp_vld_d;
      tmp_sof_q    <= tmp_sof_d;
      tmp_last_q   <= tmp_last_d;
      in_frame_q   <= in_frame_d;
      tready_q     <= tready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_axis_tready     = tready_q;
  assign ll_data_out       = out_data_q;
  assign ll_src_rdy_out_n  = src_rdy_n_q;
  assign ll_sof_out_n      = sof_n_q;
  assign ll_eof_out_n      = eof_n_q;
  assign status_busy       = in_frame_q;
  assign status_frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_ll_bridge_reg.sv
`default_nettype none
// ============================================================================
// tb_axis_ll_bridge_reg : scoreboard bench for the AXIS to LocalLink bridge.
// Revision 1.0
// ============================================================================
module tb_axis_ll_bridge_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [7:0] ll_data_out;
  logic       ll_sof_out_n;
  logic       ll_eof_out_n;
  logic       ll_src_rdy_out_n;
  logic       ll_dst_rdy_in_n;
  logic       status_busy;
  logic       status_frame_done;

  axis_ll_bridge_reg #(.DATA_WIDTH(8)) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .ll_data_out       (ll_data_out),
    .ll_sof_out_n      (ll_sof_out_n),
    .ll_eof_out_n      (ll_eof_out_n),
    .ll_src_rdy_out_n  (ll_src_rdy_out_n),
    .ll_dst_rdy_in_n   (ll_dst_rdy_in_n),
    .status_busy       (status_busy),
    .status_frame_done (status_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t exp_q[$];
  int    in_edges[$];
  int    out_edges[$];
  int    fd_edges[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    in_count = 0;
  int    out_count = 0;
  int    fd_count = 0;
  int    dst_mode = 0;
  int    stall_cnt = 0;
  logic  exp_busy_next = 1'b0;
  logic  exp_busy;
  logic  prev_eof_x = 1'b0;
  logic  hold_valid = 1'b0;
  logic [7:0] hold_data = 8'h00;
  beat_t mon_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model of the busy flag: set by a non-last accepted beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_busy <= 1'b0;
    else        exp_busy <= exp_busy_next;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_src_rdy_n"}, ll_src_rdy_out_n, 1);
    chk({tag, "_sof_n"}, ll_sof_out_n, 1);
    chk({tag, "_eof_n"}, ll_eof_out_n, 1);
    chk({tag, "_data"}, ll_data_out, 0);
    chk({tag, "_busy"}, status_busy, 0);
    chk({tag, "_frame_done"}, status_frame_done, 0);
  endtask

  // Destination-ready driver
  initial begin
    ll_dst_rdy_in_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        ll_dst_rdy_in_n = 1'b1;
        stall_cnt--;
      end else begin
        case (dst_mode)
          0:       ll_dst_rdy_in_n = 1'b0;
          1:       ll_dst_rdy_in_n = 1'($urandom_range(0, 1));
          2:       ll_dst_rdy_in_n = 1'b1;
          default: ll_dst_rdy_in_n = ~ll_dst_rdy_in_n;
        endcase
      end
    end
  end

  // Monitor: transfers become final at the next posedge, so decide at negedge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_eof_x = 1'b0;
      hold_valid = 1'b0;
    end else begin
      chk("frame_done", status_frame_done, prev_eof_x);
      if (status_frame_done) begin
        fd_count++;
        fd_edges.push_back(cyc);
      end
      chk("busy", status_busy, exp_busy);
      if (hold_valid) begin
        chk("hold_src_rdy", ll_src_rdy_out_n, 0);
        chk("hold_data", ll_data_out, hold_data);
      end
      if (ll_src_rdy_out_n) begin
        chk("idle_sof_n", ll_sof_out_n, 1);
        chk("idle_eof_n", ll_eof_out_n, 1);
      end
      prev_eof_x = 1'b0;
      hold_valid = 1'b0;
      if (!ll_src_rdy_out_n && !ll_dst_rdy_in_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", ll_data_out);
        end else begin
          mon_b = exp_q.pop_front();
          chk("out_data", ll_data_out, mon_b.d);
          chk("out_sof_n", ll_sof_out_n, !mon_b.sof);
          chk("out_eof_n", ll_eof_out_n, !mon_b.eof);
        end
        out_count++;
        out_edges.push_back(cyc + 1);
        prev_eof_x = !ll_eof_out_n;
      end else if (!ll_src_rdy_out_n) begin
        hold_valid = 1'b1;
        hold_data  = ll_data_out;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic eof);
    int    t = 0;
    bit    done = 0;
    beat_t b;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = eof;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) begin
        b.d = d;
        b.sof = sof;
        b.eof = eof;
        exp_q.push_back(b);
        in_count++;
        in_edges.push_back(cyc + 1);
        exp_busy_next = !eof;
        done = 1;
      end else if (++t > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no tready expected accept of %0h", d);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int oc0;
    int fd0;
    int gs;
    int n;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    #1;
    chk("tready_before_edge", s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", s_axis_tready, 1);

    // 4-beat frame, destination always ready
    in_edges.delete();
    out_edges.delete();
    fd_edges.delete();
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 * (i + 1)), i == 0, i == 3);
    s_axis_tvalid = 1'b0;
    drain();
    chk("f4_out_count", out_edges.size(), 4);
    if (out_edges.size() == 4 && in_edges.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("f4_latency", out_edges[i] - in_edges[i], 1);
        chk("f4_consecutive", out_edges[i] - out_edges[0], i);
      end
    end
    chk("f4_frame_done_pulses", fd_edges.size(), 1);

    // Back-to-back single-beat frames
    fd_edges.delete();
    for (int i = 0; i < 3; i++) send_beat(8'(8'hA0 + i), 1'b1, 1'b1);
    s_axis_tvalid = 1'b0;
    drain();
    chk("single_fd_pulses", fd_edges.size(), 3);
    if (fd_edges.size() == 3) begin
      chk("single_fd_gap1", fd_edges[1] - fd_edges[0], 1);
      chk("single_fd_gap2", fd_edges[2] - fd_edges[0], 2);
    end

    // 8-beat frame with a 5-cycle stall mid-frame
    out_edges.delete();
    oc0 = out_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(8'(i), i == 0, i == 7);
        s_axis_tvalid = 1'b0;
      end
      begin
        int t = 0;
        while ((out_count - oc0) < 3 && t < 500) begin
          @(posedge clk);
          #2;
          t++;
        end
        stall_cnt = 5;
        repeat (4) @(posedge clk);
        #2;
        chk("stall_tready", s_axis_tready, 0);
        chk("stall_buffered_le2", (in_count - out_count) <= 2, 1);
      end
    join
    drain();
    chk("stall_out_count", out_edges.size(), 8);
    gs = 0;
    for (int i = 1; i < out_edges.size(); i++) gs += out_edges[i] - out_edges[i-1] - 1;
    chk("stall_gap_cycles", gs, 5);

    // Randomized frames with random source and destination readiness
    dst_mode = 1;
    fd0 = fd_count;
    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
        send_beat(8'($urandom), i == 0, i == n - 1);
      end
    end
    s_axis_tvalid = 1'b0;
    drain();
    chk("random_frame_done_count", fd_count - fd0, 200);

    // Asynchronous reset after 3 of 6 beats
    dst_mode = 3;
    repeat (2) @(posedge clk);
    dst_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_beat(8'(8'hC0 + i), i == 0, 1'b0);
    s_axis_tvalid = 1'b0;
    chk("pre_reset_src_rdy_n", ll_src_rdy_out_n, 0);
    chk("pre_reset_busy", status_busy, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_busy_next = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'h55, 1'b1, 1'b0);
    send_beat(8'h66, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    drain();

    // Busy window over a 3-beat frame
    chk("busy_before", status_busy, 0);
    send_beat(8'h71, 1'b1, 1'b0);
    chk("busy_after_first", status_busy, 1);
    send_beat(8'h72, 1'b0, 1'b0);
    chk("busy_mid", status_busy, 1);
    send_beat(8'h73, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    chk("busy_after_last", status_busy, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
